// File: rtl/laptop_img_loader.sv
// laptop_img_loader: loads a row-major 8-bit grayscale frame from a valid/ready byte stream into laptop_img,
// pulses laptop_img_rdy for one cycle when the frame is complete, then holds the frame until vj_pipeline_done.
// Ports:
//   clock, reset (async, active-low)     clock and reset
//   byte_in, byte_valid, byte_sof        incoming pixel stream; sof marks pixel (0,0)
//   byte_ready                           loader can take a byte (IDLE/LOAD)
//   laptop_img [row][col]                frame register
//   laptop_img_rdy                       one-cycle frame-complete pulse
//   vj_pipeline_done                     consumer finished with the frame (honoured only in WAIT)
//   loader_busy                          frame held for the consumer (FIRE/WAIT)
//   sof_errors                           saturating count of frames aborted by an early SOF
`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 4
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 3
`endif

module laptop_img_loader #(
    parameter int WIDTH  = `LAPTOP_WIDTH,
    parameter int HEIGHT = `LAPTOP_HEIGHT,
    parameter int ERR_W  = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [7:0]                        byte_in,
    input  logic                              byte_valid,
    input  logic                              byte_sof,
    output logic                              byte_ready,
    output logic [HEIGHT-1:0][WIDTH-1:0][7:0] laptop_img,
    output logic                              laptop_img_rdy,
    input  logic                              vj_pipeline_done,
    output logic                              loader_busy,
    output logic [ERR_W-1:0]                  sof_errors
);
    localparam int RW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    // position following pixel (0,0); a one-column frame continues on row 1
    localparam logic [CW-1:0] COL_AFTER0 = CW'(WIDTH > 1 ? 1 : 0);
    localparam logic [RW-1:0] ROW_AFTER0 = RW'((WIDTH == 1 && HEIGHT > 1) ? 1 : 0);
    localparam bit SINGLE = (WIDTH * HEIGHT) == 1;

    typedef enum logic [1:0] {IDLE, LOAD, FIRE, WAIT} state_t;

    state_t          state, state_d;
    logic [RW-1:0]   row, row_d, wr_row;
    logic [CW-1:0]   col, col_d, wr_col;
    logic            accept, at_last, wr_en, err_inc;

    assign byte_ready     = state == IDLE || state == LOAD;
    assign laptop_img_rdy = state == FIRE;
    assign loader_busy    = state == FIRE || state == WAIT;
    assign accept         = byte_valid && byte_ready;
    assign at_last        = row == ROW_LAST && col == COL_LAST;

    always_comb begin
        state_d = state;
        row_d   = row;
        col_d   = col;
        wr_en   = 1'b0;
        wr_row  = row;
        wr_col  = col;
        err_inc = 1'b0;
        if (accept && byte_sof) begin
            // a SOF always restarts the frame at (0,0); inside LOAD it aborts the partial frame
            wr_en   = 1'b1;
            wr_row  = '0;
            wr_col  = '0;
            row_d   = ROW_AFTER0;
            col_d   = COL_AFTER0;
            err_inc = state == LOAD;
            state_d = SINGLE ? FIRE : LOAD;
        end else if (accept && state == LOAD) begin
            wr_en   = 1'b1;
            row_d   = at_last ? '0 : (col == COL_LAST ? row + 1'b1 : row);
            col_d   = col == COL_LAST ? '0 : col + 1'b1;
            state_d = at_last ? FIRE : LOAD;
        end else if (state == FIRE) begin
            state_d = WAIT;
        end else if (state == WAIT && vj_pipeline_done) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            laptop_img <= '0;
            sof_errors <= '0;
        end else begin
            state <= state_d;
            row   <= row_d;
            col   <= col_d;
            if (wr_en)
                laptop_img[wr_row][wr_col] <= byte_in;
            if (err_inc && sof_errors != '1)
                sof_errors <= sof_errors + 1'b1;
        end
    end
endmodule

// File: tb/tb_laptop_img_loader.sv
// tb_laptop_img_loader: directed bench for laptop_img_loader (4x3 frame plus a 1x1 instance) with a
// pixel-index behavioural model compared every cycle and literal expectations per scenario.
module tb_laptop_img_loader;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic byte_valid = 1'b0, byte_sof = 1'b0, done = 1'b0;
    logic byte_ready, rdy, busy;
    logic [H-1:0][W-1:0][7:0] img;
    logic [7:0] errs;

    logic [7:0] b1 = 8'h00;
    logic v1 = 1'b0, s1 = 1'b0, d1 = 1'b0;
    logic ready1, rdy1, busy1;
    logic [0:0][0:0][7:0] img1;
    logic [7:0] errs1;

    always #5 clock = ~clock;

    laptop_img_loader #(.WIDTH(W), .HEIGHT(H), .ERR_W(8)) dut (
        .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid), .byte_sof(byte_sof),
        .byte_ready(byte_ready), .laptop_img(img), .laptop_img_rdy(rdy), .vj_pipeline_done(done),
        .loader_busy(busy), .sof_errors(errs));

    laptop_img_loader #(.WIDTH(1), .HEIGHT(1), .ERR_W(8)) dut1 (
        .clock(clock), .reset(reset), .byte_in(b1), .byte_valid(v1), .byte_sof(s1),
        .byte_ready(ready1), .laptop_img(img1), .laptop_img_rdy(rdy1), .vj_pipeline_done(d1),
        .loader_busy(busy1), .sof_errors(errs1));

    int n_chk = 0;
    int n_fail = 0;
    int rdy_cnt = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // model: m_pos = index of the next pixel expected (-1 while hunting for SOF),
    // m_full = frame held for the consumer, m_fire = the one cycle right after completion
    int m_pos = -1;
    bit m_full = 1'b0;
    bit m_fire = 1'b0;
    int m_errs = 0;
    logic [7:0] m_img [N];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pos = -1;
            m_full = 1'b0;
            m_fire = 1'b0;
            m_errs = 0;
            foreach (m_img[i]) m_img[i] = 8'h00;
        end else if (m_fire) begin
            m_fire = 1'b0;
        end else if (m_full) begin
            if (done) m_full = 1'b0;
        end else if (byte_valid) begin
            if (byte_sof) begin
                if (m_pos > 0 && m_errs < 255) m_errs++;
                m_img[0] = byte_in;
                m_pos = 1;
            end else if (m_pos >= 0) begin
                m_img[m_pos] = byte_in;
                m_pos++;
            end
            if (m_pos == N) begin
                m_full = 1'b1;
                m_fire = 1'b1;
                m_pos = -1;
            end
        end
    end

    function automatic logic [N*8-1:0] m_flat();
        logic [N*8-1:0] f;
        for (int i = 0; i < N; i++) f[i*8 +: 8] = m_img[i];
        return f;
    endfunction

    always @(negedge clock) begin
        chk("byte_ready", byte_ready, !m_full);
        chk("img_rdy", rdy, m_fire);
        chk("loader_busy", busy, m_full);
        chk("sof_errors", errs, m_errs[7:0]);
        chk("image", img, m_flat());
        if (rdy === 1'b1) rdy_cnt++;
    end

    task automatic send(input logic [7:0] b, input logic sof);
        int k;
        byte_in = b;
        byte_sof = sof;
        byte_valid = 1'b1;
        k = 0;
        while (byte_ready !== 1'b1 && k < 100) begin
            @(posedge clock); #2;
            k++;
        end
        if (k == 100) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: byte_ready stayed %b, required 1", byte_ready);
        end
        @(posedge clock); #2;
        byte_sof = 1'b0;
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        byte_sof = 1'b0;
        repeat (n) begin
            @(posedge clock); #2;
        end
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(posedge clock); #2;
        done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        chk("rst_ready", byte_ready, 1);
        chk("rst_rdy", rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", errs, 0);
        chk("rst_img", img, 0);

        for (int i = 0; i < N; i++) send(8'(i), i == 0);
        byte_valid = 1'b0;
        chk("nom_rdy_on", rdy, 1);
        chk("nom_ready_off", byte_ready, 0);
        chk("nom_busy", busy, 1);
        chk("nom_px00", img[0][0], 8'h00);
        chk("nom_px12", img[1][2], 8'h06);
        chk("nom_px23", img[2][3], 8'h0B);
        idle(1);
        chk("nom_rdy_off", rdy, 0);
        chk("nom_busy_hold", busy, 1);
        idle(3);
        chk("nom_pulses", rdy_cnt, 1);
        pulse_done();
        chk("done_ready", byte_ready, 1);
        chk("done_busy", busy, 0);

        repeat (3) send(8'hAA, 1'b0);
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            send(8'(8'h10 + i), i == 0);
        end
        idle(2);
        chk("resync_px00", img[0][0], 8'h10);
        chk("resync_px10", img[1][0], 8'h14);
        chk("resync_px23", img[2][3], 8'h1B);
        chk("resync_errs", errs, 0);
        chk("resync_pulses", rdy_cnt, 2);
        pulse_done();

        for (int i = 0; i < 5; i++) send(8'(8'h60 + i), i == 0);
        send(8'h80, 1'b1);
        for (int i = 1; i < N; i++) send(8'(8'h80 + i), 1'b0);
        idle(2);
        chk("early_errs", errs, 1);
        chk("early_px00", img[0][0], 8'h80);
        chk("early_px11", img[1][1], 8'h85);
        chk("early_px23", img[2][3], 8'h8B);
        chk("early_pulses", rdy_cnt, 3);

        byte_in = 8'h33;
        byte_sof = 1'b1;
        byte_valid = 1'b1;
        repeat (20) begin
            @(posedge clock); #2;
        end
        chk("bp_px00", img[0][0], 8'h80);
        chk("bp_px21", img[2][1], 8'h89);
        chk("bp_busy", busy, 1);
        chk("bp_ready", byte_ready, 0);
        idle(0);
        pulse_done();
        chk("bp_done_ready", byte_ready, 1);
        for (int i = 0; i < N; i++) begin
            if (i == 4) done = 1'b1;
            send(8'(8'hF0 + i), i == 0);
            done = 1'b0;
        end
        idle(2);
        chk("second_busy", busy, 1);
        chk("second_px00", img[0][0], 8'hF0);
        chk("second_px10", img[1][0], 8'hF4);
        chk("second_px23", img[2][3], 8'hFB);
        chk("second_pulses", rdy_cnt, 4);
        pulse_done();

        for (int i = 0; i < 7; i++) send(8'(8'h40 + i), i == 0);
        byte_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("arst_ready", byte_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_rdy", rdy, 0);
        chk("arst_errs", errs, 0);
        chk("arst_img", img, 0);
        @(posedge clock); #2 reset = 1'b1;
        for (int i = 0; i < N; i++) send(8'(8'h20 + i), i == 0);
        idle(2);
        chk("post_px01", img[0][1], 8'h21);
        chk("post_px23", img[2][3], 8'h2B);
        chk("post_pulses", rdy_cnt, 5);
        pulse_done();

        b1 = 8'h5A;
        s1 = 1'b1;
        v1 = 1'b1;
        @(posedge clock); #2;
        v1 = 1'b0;
        s1 = 1'b0;
        chk("one_rdy", rdy1, 1);
        chk("one_px", img1[0][0], 8'h5A);
        chk("one_ready", ready1, 0);
        chk("one_busy", busy1, 1);
        @(posedge clock); #2;
        chk("one_rdy_off", rdy1, 0);
        chk("one_wait", busy1, 1);
        d1 = 1'b1;
        @(posedge clock); #2;
        d1 = 1'b0;
        chk("one_done_ready", ready1, 1);
        chk("one_done_busy", busy1, 0);
        chk("one_errs", errs1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/laptop_img_loader.md
# laptop_img_loader

Hardware frame loader that feeds `detect_face` its input image. It accepts a raw 8-bit grayscale pixel byte stream from the host link (valid/ready, start-of-frame flagged) and writes it row-major into the `laptop_img` frame register. It pulses `laptop_img_rdy` for one cycle when a full frame is present. It then holds the image stable and refuses new bytes until `detect_face` reports `vj_pipeline_done`.

## Interface
Parameters:
- `WIDTH`, default `` `LAPTOP_WIDTH ``: pixels per row.
- `HEIGHT`, default `` `LAPTOP_HEIGHT ``: rows per frame.
- `ERR_W`, default 8: width of the `sof_errors` counter.

Ports:
- `clock`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset).
- `byte_in`  input  8  pixel value.
- `byte_valid`  input  1  `byte_in` is valid this cycle.
- `byte_sof`  input  1  qualifies `byte_in` as pixel (0,0) of a new frame.
- `byte_ready`  output  1  loader accepts a byte this cycle.
- `laptop_img`  output  `[HEIGHT-1:0][WIDTH-1:0][7:0]`  frame register, indexed `[row][col]`.
- `laptop_img_rdy`  output  1  one-cycle pulse: frame complete and stable.
- `vj_pipeline_done`  input  1  pulse from `detect_face`: current image fully consumed.
- `loader_busy`  output  1  high in FIRE and WAIT.
- `sof_errors`  output  `ERR_W`  saturating count of frames aborted by an early SOF.

## Operation
- **Accept:** a byte is accepted at a rising edge where `byte_valid && byte_ready`.
- **`byte_ready`:** decoded from state. It is 1 in IDLE and LOAD, and 0 in FIRE and WAIT.
- **State IDLE:**
  - An accepted byte with `byte_sof=0` is consumed and discarded. This resyncs the stream.
  - An accepted byte with `byte_sof=1` is written to `laptop_img[0][0]`, sets `col=1`, `row=0`, and moves to LOAD.
  - If `WIDTH*HEIGHT==1`, it moves straight to FIRE.
- **State LOAD:**
  - An accepted byte with `byte_sof=0` writes `laptop_img[row][col]`.
  - `col` increments, wrapping to 0 at `WIDTH-1`, which increments `row`.
  - When the byte written is at (`HEIGHT-1`, `WIDTH-1`), the state moves to FIRE.
- **Early SOF in LOAD:** an accepted byte with `byte_sof=1` aborts the partial frame. It is written to (0,0), sets `col=1`/`row=0`, stays in LOAD, and increments `sof_errors`, saturating at all-ones. Pixels of the aborted frame are overwritten as the new frame arrives.
- **State FIRE:** lasts one cycle with `laptop_img_rdy=1`, then moves to WAIT.
- **State WAIT:** `laptop_img` is frozen. The state moves to IDLE on the cycle after `vj_pipeline_done` is sampled high.
- **`vj_pipeline_done` outside WAIT:** ignored.
- **Counters:** `row` is `$clog2(HEIGHT)` bits and `col` is `$clog2(WIDTH)` bits (minimum 1 bit each). Neither ever exceeds its bound.
- **Pixel bytes:** stored unmodified, no arithmetic.

## Timing
- **Reset values** (while `reset=0`, asynchronously):
  - state IDLE, `byte_ready=1`, `laptop_img_rdy=0`, `loader_busy=0`, `sof_errors=0`;
  - `laptop_img` all zeros; `row`/`col`=0.
- **Ready after reset:** `byte_ready` is 1 in the first cycle after `reset` deasserts.
- **Frame latency:** last pixel accepted at edge N → `laptop_img_rdy=1` during cycle N..N+1, with the full image already visible. `byte_ready=0` from edge N onward.
- **`laptop_img_rdy`:** never high for more than one consecutive cycle, and fires exactly once per completed frame.
- **Done handshake:** `vj_pipeline_done` sampled at edge M in WAIT → `byte_ready=1` after edge M+1... precisely: state is IDLE after edge M, so `byte_ready=1` in cycle M..M+1.
- **Minimum spacing:** `laptop_img_rdy` pulses are at least `WIDTH*HEIGHT+2` cycles apart.
- **Throughput:** one byte per cycle in LOAD, with no bubbles required.
- **Reset mid-frame:** all progress is lost. No `laptop_img_rdy` is emitted for the partial frame.

## Test plan
Use `WIDTH=4`, `HEIGHT=3` unless noted.
- **Reset values:** hold `reset=0` 3 cycles, release → all outputs at reset values, `byte_ready=1`, `laptop_img` all 0.
- **Nominal frame:** stream 0x00..0x0B back-to-back, `byte_sof` on 0x00 → `laptop_img[r][c] = 4r+c`. `laptop_img_rdy` is high exactly one cycle, starting the edge of the 12th accept. `byte_ready=0` and `loader_busy=1` until done.
- **Resync and gapped valid:** send 3 bytes with `byte_sof=0` (0xAA) in IDLE, then a frame with random valid gaps → the 0xAA bytes are discarded and the image matches the frame data. `sof_errors=0`.
- **Early SOF:** after 5 bytes, assert `byte_sof` with 0x80, then 11 more bytes 0x81..0x8B → `sof_errors=1`, `laptop_img[r][c] = 0x80+4r+c`, one `laptop_img_rdy` pulse.
- **Back-pressure and done:**
  - Hold `byte_valid=1` during WAIT for 20 cycles → no bytes consumed and the image is unchanged.
  - Pulse `vj_pipeline_done` → `byte_ready=1` the next cycle, and a second frame (0xF0..0xFB) overwrites the image.
  - A `vj_pipeline_done` pulse during LOAD has no effect.
- **Async reset mid-LOAD:** after 7 bytes, drop `reset` between edges → outputs clear immediately and no `laptop_img_rdy` occurs. A following full frame loads correctly. Also run with `WIDTH=HEIGHT=1`: one SOF byte 0x5A → immediate FIRE and `laptop_img[0][0]=0x5A`.
